// File: rtl/hc_multi_core_arbiter.sv
// Shares one CCI-P/MPF read channel (c0) and write channel (c1) among NUM_CORES cores.
// Round-robin grant, core-id mdata tagging, per-core credit limits and response routing.
module hc_multi_core_arbiter #(
  parameter int NUM_CORES    = 4,
  parameter int ADDR_W       = 42,
  parameter int DATA_W       = 512,
  parameter int MDATA_W      = 16,
  parameter int MAX_OUTSTAND = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          rd_req_valid,
  input  logic [NUM_CORES*ADDR_W-1:0]   rd_req_addr,
  output logic [NUM_CORES-1:0]          rd_req_ready,
  output logic [NUM_CORES-1:0]          rd_rsp_valid,
  output logic [DATA_W-1:0]             rd_rsp_data,
  input  logic [NUM_CORES-1:0]          wr_req_valid,
  input  logic [NUM_CORES*ADDR_W-1:0]   wr_req_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   wr_req_data,
  output logic [NUM_CORES-1:0]          wr_req_ready,
  output logic [NUM_CORES-1:0]          wr_rsp_valid,
  output logic                          c0_tx_valid,
  output logic [ADDR_W-1:0]             c0_tx_addr,
  output logic [MDATA_W-1:0]            c0_tx_mdata,
  input  logic                          c0_almfull,
  input  logic                          c0_rx_valid,
  input  logic [MDATA_W-1:0]            c0_rx_mdata,
  input  logic [DATA_W-1:0]             c0_rx_data,
  output logic                          c1_tx_valid,
  output logic [ADDR_W-1:0]             c1_tx_addr,
  output logic [DATA_W-1:0]             c1_tx_data,
  output logic [MDATA_W-1:0]            c1_tx_mdata,
  input  logic                          c1_almfull,
  input  logic                          c1_rx_valid,
  input  logic [MDATA_W-1:0]            c1_rx_mdata,
  output logic                          idle,
  output logic                          err_bad_id
);

  localparam int ID_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTAND + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_OUTSTAND);
  localparam logic [MDATA_W-1:0] ID_LIMIT = MDATA_W'(NUM_CORES);

  // Returns {found, id}: first set bit of elig at or after ptr, wrapping.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_CORES-1:0] elig,
                                            input logic [ID_W-1:0] ptr);
    logic [ID_W:0] res;
    int j;
    res = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_CORES;
      if (elig[j]) res = {1'b1, ID_W'(j)};
    end
    return res;
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_CORES - 1)) ? '0 : id + 1'b1;
  endfunction

  logic [ID_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     rd_cnt_q [NUM_CORES];
  logic [CNT_W-1:0]     rd_cnt_d [NUM_CORES];
  logic [CNT_W-1:0]     wr_cnt_q [NUM_CORES];
  logic [CNT_W-1:0]     wr_cnt_d [NUM_CORES];
  logic [NUM_CORES-1:0] rd_elig, wr_elig;
  logic                 rd_gnt, wr_gnt;
  logic [ID_W-1:0]      rd_gnt_id, wr_gnt_id;
  logic [ID_W-1:0]      rd_rx_id, wr_rx_id;
  logic                 rd_rx_ok, wr_rx_ok, rd_rx_bad, wr_rx_bad;
  logic                 cnt_zero;

  logic                 c0_tx_valid_q, c0_tx_valid_d;
  logic [ADDR_W-1:0]    c0_tx_addr_q, c0_tx_addr_d;
  logic [MDATA_W-1:0]   c0_tx_mdata_q, c0_tx_mdata_d;
  logic                 c1_tx_valid_q, c1_tx_valid_d;
  logic [ADDR_W-1:0]    c1_tx_addr_q, c1_tx_addr_d;
  logic [DATA_W-1:0]    c1_tx_data_q, c1_tx_data_d;
  logic [MDATA_W-1:0]   c1_tx_mdata_q, c1_tx_mdata_d;
  logic [NUM_CORES-1:0] rd_rsp_valid_q, rd_rsp_valid_d;
  logic [NUM_CORES-1:0] wr_rsp_valid_q, wr_rsp_valid_d;
  logic [DATA_W-1:0]    rd_rsp_data_q, rd_rsp_data_d;
  logic                 err_q, err_d;

  // Arbitration; ready is withheld during reset so nothing is accepted then.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      rd_elig[i] = rd_req_valid[i] && (rd_cnt_q[i] < CNT_MAX) && !c0_almfull && !reset;
      wr_elig[i] = wr_req_valid[i] && (wr_cnt_q[i] < CNT_MAX) && !c1_almfull && !reset;
    end
    {rd_gnt, rd_gnt_id} = rr_pick(rd_elig, rd_ptr_q);
    {wr_gnt, wr_gnt_id} = rr_pick(wr_elig, wr_ptr_q);
    rd_req_ready = '0;
    wr_req_ready = '0;
    if (rd_gnt) rd_req_ready[rd_gnt_id] = 1'b1;
    if (wr_gnt) wr_req_ready[wr_gnt_id] = 1'b1;
  end

  // The full mdata is checked: we only ever send {zero pad, id}, so any high bit is foreign.
  always_comb begin
    rd_rx_id  = c0_rx_mdata[ID_W-1:0];
    wr_rx_id  = c1_rx_mdata[ID_W-1:0];
    rd_rx_ok  = c0_rx_valid && (c0_rx_mdata < ID_LIMIT) && (rd_cnt_q[rd_rx_id] != '0);
    wr_rx_ok  = c1_rx_valid && (c1_rx_mdata < ID_LIMIT) && (wr_cnt_q[wr_rx_id] != '0);
    rd_rx_bad = c0_rx_valid && !rd_rx_ok;
    wr_rx_bad = c1_rx_valid && !wr_rx_ok;
  end

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      rd_cnt_d[i] = rd_cnt_q[i];
      wr_cnt_d[i] = wr_cnt_q[i];
      case ({rd_gnt && (rd_gnt_id == ID_W'(i)), rd_rx_ok && (rd_rx_id == ID_W'(i))})
        2'b10:   rd_cnt_d[i] = rd_cnt_q[i] + 1'b1;
        2'b01:   rd_cnt_d[i] = rd_cnt_q[i] - 1'b1;
        default: rd_cnt_d[i] = rd_cnt_q[i];
      endcase
      case ({wr_gnt && (wr_gnt_id == ID_W'(i)), wr_rx_ok && (wr_rx_id == ID_W'(i))})
        2'b10:   wr_cnt_d[i] = wr_cnt_q[i] + 1'b1;
        2'b01:   wr_cnt_d[i] = wr_cnt_q[i] - 1'b1;
        default: wr_cnt_d[i] = wr_cnt_q[i];
      endcase
    end
  end

  always_comb begin
    rd_ptr_d      = rd_gnt ? next_ptr(rd_gnt_id) : rd_ptr_q;
    wr_ptr_d      = wr_gnt ? next_ptr(wr_gnt_id) : wr_ptr_q;
    c0_tx_valid_d = rd_gnt;
    c0_tx_addr_d  = rd_gnt ? rd_req_addr[rd_gnt_id*ADDR_W +: ADDR_W] : c0_tx_addr_q;
    c0_tx_mdata_d = rd_gnt ? MDATA_W'(rd_gnt_id) : c0_tx_mdata_q;
    c1_tx_valid_d = wr_gnt;
    c1_tx_addr_d  = wr_gnt ? wr_req_addr[wr_gnt_id*ADDR_W +: ADDR_W] : c1_tx_addr_q;
    c1_tx_data_d  = wr_gnt ? wr_req_data[wr_gnt_id*DATA_W +: DATA_W] : c1_tx_data_q;
    c1_tx_mdata_d = wr_gnt ? MDATA_W'(wr_gnt_id) : c1_tx_mdata_q;
    rd_rsp_valid_d = '0;
    wr_rsp_valid_d = '0;
    if (rd_rx_ok) rd_rsp_valid_d[rd_rx_id] = 1'b1;
    if (wr_rx_ok) wr_rsp_valid_d[wr_rx_id] = 1'b1;
    rd_rsp_data_d = rd_rx_ok ? c0_rx_data : rd_rsp_data_q;
    err_d         = err_q | rd_rx_bad | wr_rx_bad;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        rd_cnt_q[i] <= '0;
        wr_cnt_q[i] <= '0;
      end
      c0_tx_valid_q  <= 1'b0;
      c0_tx_addr_q   <= '0;
      c0_tx_mdata_q  <= '0;
      c1_tx_valid_q  <= 1'b0;
      c1_tx_addr_q   <= '0;
      c1_tx_data_q   <= '0;
      c1_tx_mdata_q  <= '0;
      rd_rsp_valid_q <= '0;
      wr_rsp_valid_q <= '0;
      rd_rsp_data_q  <= '0;
      err_q          <= 1'b0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        rd_cnt_q[i] <= rd_cnt_d[i];
        wr_cnt_q[i] <= wr_cnt_d[i];
      end
      c0_tx_valid_q  <= c0_tx_valid_d;
      c0_tx_addr_q   <= c0_tx_addr_d;
      c0_tx_mdata_q  <= c0_tx_mdata_d;
      c1_tx_valid_q  <= c1_tx_valid_d;
      c1_tx_addr_q   <= c1_tx_addr_d;
      c1_tx_data_q   <= c1_tx_data_d;
      c1_tx_mdata_q  <= c1_tx_mdata_d;
      rd_rsp_valid_q <= rd_rsp_valid_d;
      wr_rsp_valid_q <= wr_rsp_valid_d;
      rd_rsp_data_q  <= rd_rsp_data_d;
      err_q          <= err_d;
    end
  end

  always_comb begin
    cnt_zero = 1'b1;
    for (int i = 0; i < NUM_CORES; i++) begin
      if ((rd_cnt_q[i] != '0) || (wr_cnt_q[i] != '0)) cnt_zero = 1'b0;
    end
    idle = !c0_tx_valid_q && !c1_tx_valid_q && !(|rd_rsp_valid_q) && !(|wr_rsp_valid_q)
           && cnt_zero;
  end

  assign c0_tx_valid  = c0_tx_valid_q;
  assign c0_tx_addr   = c0_tx_addr_q;
  assign c0_tx_mdata  = c0_tx_mdata_q;
  assign c1_tx_valid  = c1_tx_valid_q;
  assign c1_tx_addr   = c1_tx_addr_q;
  assign c1_tx_data   = c1_tx_data_q;
  assign c1_tx_mdata  = c1_tx_mdata_q;
  assign rd_rsp_valid = rd_rsp_valid_q;
  assign wr_rsp_valid = wr_rsp_valid_q;
  assign rd_rsp_data  = rd_rsp_data_q;
  assign err_bad_id   = err_q;

endmodule

// File: tb/tb_hc_multi_core_arbiter.sv
// Randomized and directed bench for hc_multi_core_arbiter; a credit/round-robin reference
// model feeds scoreboards that a separate monitor drains as the DUT emits transactions.
module tb_hc_multi_core_arbiter;
  localparam int N = 4, AW = 42, DW = 512, MW = 16, MAXO = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0]    rd_req_valid = '0, rd_req_ready, rd_rsp_valid;
  logic [N*AW-1:0] rd_req_addr = '0;
  logic [DW-1:0]   rd_rsp_data;
  logic [N-1:0]    wr_req_valid = '0, wr_req_ready, wr_rsp_valid;
  logic [N*AW-1:0] wr_req_addr = '0;
  logic [N*DW-1:0] wr_req_data = '0;
  logic            c0_tx_valid, c1_tx_valid, idle, err_bad_id;
  logic [AW-1:0]   c0_tx_addr, c1_tx_addr;
  logic [MW-1:0]   c0_tx_mdata, c1_tx_mdata;
  logic [DW-1:0]   c1_tx_data;
  logic            c0_almfull = 1'b0, c1_almfull = 1'b0;
  logic            c0_rx_valid = 1'b0, c1_rx_valid = 1'b0;
  logic [MW-1:0]   c0_rx_mdata = '0, c1_rx_mdata = '0;
  logic [DW-1:0]   c0_rx_data = '0;

  hc_multi_core_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MDATA_W(MW),
                          .MAX_OUTSTAND(MAXO)) dut (
    .clk(clk), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_req_ready(wr_req_ready), .wr_rsp_valid(wr_rsp_valid),
    .c0_tx_valid(c0_tx_valid), .c0_tx_addr(c0_tx_addr), .c0_tx_mdata(c0_tx_mdata),
    .c0_almfull(c0_almfull), .c0_rx_valid(c0_rx_valid), .c0_rx_mdata(c0_rx_mdata),
    .c0_rx_data(c0_rx_data),
    .c1_tx_valid(c1_tx_valid), .c1_tx_addr(c1_tx_addr), .c1_tx_data(c1_tx_data),
    .c1_tx_mdata(c1_tx_mdata), .c1_almfull(c1_almfull), .c1_rx_valid(c1_rx_valid),
    .c1_rx_mdata(c1_rx_mdata), .idle(idle), .err_bad_id(err_bad_id));

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [MW-1:0] md; } tx_t;
  typedef struct { logic [N-1:0] onehot; logic [DW-1:0] data; } rsp_t;
  tx_t  rd_tx_q[$], wr_tx_q[$];
  rsp_t rd_rsp_q[$], wr_rsp_q[$];

  int n_checks = 0, n_errors = 0;

  // Reference model state
  int m_rd_cnt[N], m_wr_cnt[N];
  int m_rd_ptr = 0, m_wr_ptr = 0;
  bit m_err = 0, exp_err = 0, exp_idle = 1, have_exp = 0;
  int last_rg = -1;

  // Stimulus staging
  bit            s_reset = 1, s_c0_af = 0, s_c1_af = 0, s_c0_rx_v = 0, s_c1_rx_v = 0;
  logic [N-1:0]  s_rd_v = '0, s_wr_v = '0;
  logic [MW-1:0] s_c0_rx_md = '0, s_c1_rx_md = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[AW-1:0];
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  // Round-robin rule: first requesting core with spare credit, starting at the pointer.
  function automatic int model_grant(input logic [N-1:0] v, input int cnt[N], input int ptr,
                                     input bit af);
    int c;
    if (af) return -1;
    for (int k = 0; k < N; k++) begin
      c = (ptr + k) % N;
      if (v[c] && cnt[c] < MAXO) return c;
    end
    return -1;
  endfunction

  function automatic int pick_outstanding(input int cnt[N]);
    int live[$];
    for (int k = 0; k < N; k++) if (cnt[k] > 0) live.push_back(k);
    if (live.size() == 0) return -1;
    return live[$urandom_range(0, live.size() - 1)];
  endfunction

  task automatic step();
    int rg, wg, rid, wid;
    bit ra, wa, all0;
    logic [N-1:0] er, ew;
    tx_t t;
    rsp_t r;
    @(negedge clk);
    if (have_exp) begin
      chk("err_bad_id", err_bad_id, exp_err);
      chk("idle", idle, exp_idle);
    end
    reset = s_reset;
    rd_req_valid = s_rd_v;
    wr_req_valid = s_wr_v;
    for (int k = 0; k < N; k++) begin
      rd_req_addr[k*AW +: AW] = rnd_addr();
      wr_req_addr[k*AW +: AW] = rnd_addr();
      wr_req_data[k*DW +: DW] = rnd_data();
    end
    c0_almfull = s_c0_af;  c1_almfull = s_c1_af;
    c0_rx_valid = s_c0_rx_v; c0_rx_mdata = s_c0_rx_md; c0_rx_data = rnd_data();
    c1_rx_valid = s_c1_rx_v; c1_rx_mdata = s_c1_rx_md;
    #1;
    rg = s_reset ? -1 : model_grant(s_rd_v, m_rd_cnt, m_rd_ptr, s_c0_af);
    wg = s_reset ? -1 : model_grant(s_wr_v, m_wr_cnt, m_wr_ptr, s_c1_af);
    er = '0; ew = '0;
    if (rg >= 0) er[rg] = 1'b1;
    if (wg >= 0) ew[wg] = 1'b1;
    chk("rd_req_ready", rd_req_ready, er);
    chk("wr_req_ready", wr_req_ready, ew);
    if (rg >= 0) begin
      t.addr = rd_req_addr[rg*AW +: AW]; t.data = '0; t.md = MW'(rg);
      rd_tx_q.push_back(t);
    end
    if (wg >= 0) begin
      t.addr = wr_req_addr[wg*AW +: AW]; t.data = wr_req_data[wg*DW +: DW]; t.md = MW'(wg);
      wr_tx_q.push_back(t);
    end
    ra = 0; wa = 0; rid = 0; wid = 0;
    if (!s_reset && s_c0_rx_v) begin
      if (s_c0_rx_md >= N) m_err = 1;
      else begin
        rid = int'(s_c0_rx_md);
        if (m_rd_cnt[rid] == 0) m_err = 1; else ra = 1;
      end
    end
    if (!s_reset && s_c1_rx_v) begin
      if (s_c1_rx_md >= N) m_err = 1;
      else begin
        wid = int'(s_c1_rx_md);
        if (m_wr_cnt[wid] == 0) m_err = 1; else wa = 1;
      end
    end
    if (ra) begin r.onehot = '0; r.onehot[rid] = 1'b1; r.data = c0_rx_data; rd_rsp_q.push_back(r); end
    if (wa) begin r.onehot = '0; r.onehot[wid] = 1'b1; r.data = '0; wr_rsp_q.push_back(r); end
    if (rg >= 0) begin m_rd_cnt[rg]++; m_rd_ptr = (rg + 1) % N; end
    if (wg >= 0) begin m_wr_cnt[wg]++; m_wr_ptr = (wg + 1) % N; end
    if (ra) m_rd_cnt[rid]--;
    if (wa) m_wr_cnt[wid]--;
    if (s_reset) begin
      for (int k = 0; k < N; k++) begin m_rd_cnt[k] = 0; m_wr_cnt[k] = 0; end
      m_rd_ptr = 0; m_wr_ptr = 0; m_err = 0;
    end
    all0 = 1;
    for (int k = 0; k < N; k++) if (m_rd_cnt[k] != 0 || m_wr_cnt[k] != 0) all0 = 0;
    exp_idle = s_reset ? 1'b1 : (rg < 0 && wg < 0 && !ra && !wa && all0);
    exp_err  = m_err;
    have_exp = 1;
    last_rg  = rg;
  endtask

  task automatic quiet();
    s_rd_v = '0; s_wr_v = '0; s_c0_af = 0; s_c1_af = 0;
    s_c0_rx_v = 0; s_c1_rx_v = 0; s_c0_rx_md = '0; s_c1_rx_md = '0;
  endtask

  task automatic do_reset();
    quiet();
    s_reset = 1; step(); step();
    s_reset = 0; step();
  endtask

  // Monitor: every DUT output transaction must match the head of its scoreboard, one cycle on.
  initial begin
    tx_t t;
    rsp_t r;
    forever begin
      @(posedge clk); #1;
      if (c0_tx_valid === 1'b1) begin
        if (rd_tx_q.size() == 0) chk("c0_tx_valid", c0_tx_valid, 1'b0);
        else begin
          t = rd_tx_q.pop_front();
          chk("c0_tx_addr", c0_tx_addr, t.addr);
          chk("c0_tx_mdata", c0_tx_mdata, t.md);
        end
      end else if (rd_tx_q.size() != 0) begin
        t = rd_tx_q.pop_front(); chk("c0_tx_valid", c0_tx_valid, 1'b1);
      end
      if (c1_tx_valid === 1'b1) begin
        if (wr_tx_q.size() == 0) chk("c1_tx_valid", c1_tx_valid, 1'b0);
        else begin
          t = wr_tx_q.pop_front();
          chk("c1_tx_addr", c1_tx_addr, t.addr);
          chk("c1_tx_data", c1_tx_data, t.data);
          chk("c1_tx_mdata", c1_tx_mdata, t.md);
        end
      end else if (wr_tx_q.size() != 0) begin
        t = wr_tx_q.pop_front(); chk("c1_tx_valid", c1_tx_valid, 1'b1);
      end
      if (rd_rsp_valid !== '0 && rd_rsp_valid !== 'x) begin
        if (rd_rsp_q.size() == 0) chk("rd_rsp_valid", rd_rsp_valid, '0);
        else begin
          r = rd_rsp_q.pop_front();
          chk("rd_rsp_valid", rd_rsp_valid, r.onehot);
          chk("rd_rsp_data", rd_rsp_data, r.data);
        end
      end else if (rd_rsp_q.size() != 0) begin
        r = rd_rsp_q.pop_front(); chk("rd_rsp_valid", rd_rsp_valid, r.onehot);
      end
      if (wr_rsp_valid !== '0 && wr_rsp_valid !== 'x) begin
        if (wr_rsp_q.size() == 0) chk("wr_rsp_valid", wr_rsp_valid, '0);
        else begin
          r = wr_rsp_q.pop_front();
          chk("wr_rsp_valid", wr_rsp_valid, r.onehot);
        end
      end else if (wr_rsp_q.size() != 0) begin
        r = wr_rsp_q.pop_front(); chk("wr_rsp_valid", wr_rsp_valid, r.onehot);
      end
    end
  end

  initial begin
    logic [N-1:0] rr_exp[5];
    int ids[10];
    int c, guard;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    for (int k = 0; k < N; k++) begin m_rd_cnt[k] = 0; m_wr_cnt[k] = 0; end

    do_reset();
    chk("reset_c0_tx_addr", c0_tx_addr, '0);
    chk("reset_rd_rsp_data", rd_rsp_data, '0);

    // Round-robin order with every core requesting
    s_rd_v = 4'hF; s_wr_v = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_order_rd", rd_req_ready, rr_exp[i]);
      chk("rr_order_wr", wr_req_ready, rr_exp[i]);
    end

    // Credit limit on core 2
    do_reset();
    s_rd_v = 4'b0100;
    for (int i = 0; i < MAXO; i++) step();
    s_rd_v = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("core2_blocked", rd_req_ready[2], 1'b0);
      chk("others_granted", |rd_req_ready, 1'b1);
    end
    s_rd_v = 4'b0100; s_c0_rx_v = 1; s_c0_rx_md = 16'd2;
    step();
    s_c0_rx_v = 0;
    step();
    chk("core2_regrant", rd_req_ready, 4'b0100);

    // almfull holds the pointer
    do_reset();
    s_rd_v = 4'hF;
    step();
    s_c0_af = 1;
    for (int i = 0; i < 5; i++) begin step(); chk("almfull_no_grant", rd_req_ready, '0); end
    s_c0_af = 0;
    step();
    chk("almfull_resume", rd_req_ready, 4'b0010);

    // Simultaneous grant and response on core 1
    do_reset();
    s_rd_v = 4'b0010;
    for (int i = 0; i < 3; i++) step();
    s_c0_rx_v = 1; s_c0_rx_md = 16'd1;
    step();
    s_rd_v = '0; s_c0_rx_v = 0;
    step();
    chk("same_cycle_rsp", rd_rsp_valid, 4'b0010);
    s_c0_rx_v = 1;
    for (int i = 0; i < 4; i++) step();
    s_c0_rx_v = 0;
    step();
    chk("fourth_rsp_dropped", err_bad_id, 1'b1);

    // Out-of-range id
    do_reset();
    s_c0_rx_v = 1; s_c0_rx_md = 16'd5;
    step();
    s_c0_rx_v = 0;
    step();
    chk("bad_id_no_rsp", rd_rsp_valid, '0);
    chk("bad_id_err", err_bad_id, 1'b1);
    for (int i = 0; i < 3; i++) step();

    // Reset with reads in flight, then the late responses
    do_reset();
    s_rd_v = 4'hF;
    for (int i = 0; i < 10; i++) begin step(); ids[i] = last_rg; end
    do_reset();
    s_c0_rx_v = 1;
    for (int i = 0; i < 10; i++) begin s_c0_rx_md = MW'(ids[i]); step(); end
    s_c0_rx_v = 0;
    step(); step();
    chk("late_rsp_err", err_bad_id, 1'b1);
    chk("late_rsp_idle", idle, 1'b1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      s_rd_v = N'($urandom()); s_wr_v = N'($urandom());
      s_c0_af = ($urandom_range(0, 7) == 0);
      s_c1_af = ($urandom_range(0, 7) == 0);
      c = pick_outstanding(m_rd_cnt);
      s_c0_rx_v = ($urandom_range(0, 1) == 1) && (c >= 0);
      s_c0_rx_md = (c >= 0) ? MW'(c) : '0;
      if ($urandom_range(0, 31) == 0) begin s_c0_rx_v = 1; s_c0_rx_md = MW'($urandom()); end
      c = pick_outstanding(m_wr_cnt);
      s_c1_rx_v = ($urandom_range(0, 1) == 1) && (c >= 0);
      s_c1_rx_md = (c >= 0) ? MW'(c) : '0;
      if ($urandom_range(0, 31) == 0) begin s_c1_rx_v = 1; s_c1_rx_md = MW'($urandom()); end
      step();
    end

    // Drain everything outstanding, bounded
    quiet();
    guard = 0;
    while ((pick_outstanding(m_rd_cnt) >= 0 || pick_outstanding(m_wr_cnt) >= 0) && guard < 600) begin
      c = pick_outstanding(m_rd_cnt);
      s_c0_rx_v = (c >= 0); s_c0_rx_md = (c >= 0) ? MW'(c) : '0;
      c = pick_outstanding(m_wr_cnt);
      s_c1_rx_v = (c >= 0); s_c1_rx_md = (c >= 0) ? MW'(c) : '0;
      step();
      guard++;
    end
    chk("drain_bound", guard < 600, 1'b1);
    quiet();
    step(); step(); step();
    chk("drained_idle", idle, 1'b1);
    chk("rd_tx_scoreboard_empty", rd_tx_q.size(), 0);
    chk("rd_rsp_scoreboard_empty", rd_rsp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
